risc_v_mike_lsu: RTL

- Load/store initiator between the core's execute stage and the word-organised data memory.
- Accepts one byte, halfword or word load/store request per transaction using RV32I funct3 encodings.
- Sub-word stores are performed as read-modify-write, because the memory only writes whole 32-bit words.
- Load data is sign- or zero-extended, then returned with a valid/ready response handshake; misaligned and out-of-range accesses are flagged.

---
 rtl/risc_v_mike_lsu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/risc_v_mike_lsu.sv
// Load/store unit between execute and a word-organised data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module risc_v_mike_lsu #(
    parameter int DATA_MEM_DEPTH = 16,
    parameter int MEM_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_write,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE_W,
        RESP
    } state_t;

    state_t                state_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [MEM_ADDR_W-1:0] wordIdx_q;
    logic [15:0]           wdata_q;
    logic [31:0]           merge_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic        reqIllegal;
    logic        reqMisaligned;
    logic        reqOutOfRange;
    logic        reqErr;
    logic [31:0] reqWordAddr;
    logic [31:0] laneWord;
    logic [31:0] loadData_d;
    logic [31:0] merge_d;

    always_comb begin
        reqWordAddr   = {2'b00, req_addr[31:2]};
        reqOutOfRange = (reqWordAddr >= 32'(DATA_MEM_DEPTH));
        reqMisaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        case (req_funct3)
            3'b000, 3'b001, 3'b010: reqIllegal = 1'b0;
            3'b100, 3'b101:         reqIllegal = req_we;
            default:                reqIllegal = 1'b1;
        endcase
        reqErr = reqIllegal || reqMisaligned || reqOutOfRange;
    end

    // Shifting the addressed lane down to bit 0 lets both widths share one extractor.
    always_comb begin
        laneWord = mem_rd_data >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  loadData_d = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b001:  loadData_d = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b100:  loadData_d = {24'h000000, laneWord[7:0]};
            3'b101:  loadData_d = {16'h0000, laneWord[15:0]};
            default: loadData_d = mem_rd_data;
        endcase
    end

    always_comb begin
        merge_d = mem_rd_data;
        if (funct3_q[1:0] == 2'b00) begin
            merge_d[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_d[{offset_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
            wordIdx_q <= '0;
            wdata_q   <= 16'h0000;
            merge_q   <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        offset_q  <= req_addr[1:0];
                        wordIdx_q <= req_addr[MEM_ADDR_W+1:2];
                        wdata_q   <= req_wdata[15:0];
                        rdata_q   <= 32'h0000_0000;
                        err_q     <= reqErr;
                        if (reqErr) begin
                            state_q <= RESP;
                        end else if (!req_we) begin
                            state_q <= LOAD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            merge_q <= req_wdata;
                            state_q <= STORE_W;
                        end else begin
                            state_q <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= loadData_d;
                    state_q <= RESP;
                end
                RMW_RD: begin
                    merge_q <= merge_d;
                    state_q <= STORE_W;
                end
                STORE_W: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gating with rst lets a reset in STORE_W cancel the write on that same edge.
    assign mem_write   = (state_q == STORE_W) && rst;
    assign mem_addr    = wordIdx_q;
    assign mem_wr_data = merge_q;
    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

endmodule
